// File: rtl/lamp_pkg.sv
// Shared types for the lamp chaser: controller state and pattern mode encodings.
package lamp_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [MODE_W-1:0] MODE_FWD   = 2'b00;
    localparam logic [MODE_W-1:0] MODE_REV   = 2'b01;
    localparam logic [MODE_W-1:0] MODE_PP    = 2'b10;
    localparam logic [MODE_W-1:0] MODE_BLINK = 2'b11;

endpackage

// File: rtl/lamp_tick_gen.sv
// Prescaler: counts 0..div while enabled and flags the clock where the count reaches div.
module lamp_tick_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rset,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == div);

    // Count freezes while en is low so a paused run resumes mid-period.
    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == div) ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/lamp_chase_ctrl.sv
// Commanded lamp chaser: latches a run configuration on start and steps the lamp
// pattern once per prescaler tick until the step limit, a stop, or reset.
module lamp_chase_ctrl
    import lamp_pkg::*;
#(
    parameter int unsigned NLAMP = 4,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [MODE_W-1:0] mode,
    input  logic [DIV_W-1:0]  div,
    input  logic [CNT_W-1:0]  nsteps,
    output logic [NLAMP-1:0]  lamp,
    output logic              busy,
    output logic              done
);

    localparam logic [NLAMP-1:0] LAMP_LSB = NLAMP'(1);
    localparam logic [NLAMP-1:0] LAMP_MSB = LAMP_LSB << (NLAMP - 1);
    localparam logic [NLAMP-1:0] LAMP_ALL = '1;

    state_t              state, state_nxt;
    logic [NLAMP-1:0]    lamp_nxt;
    logic                busy_nxt, done_nxt;
    logic                dir_up, dir_up_nxt;
    logic [CNT_W-1:0]    step, step_nxt, step_inc;
    logic [MODE_W-1:0]   mode_l, mode_l_nxt;
    logic [DIV_W-1:0]    div_l, div_l_nxt;
    logic [CNT_W-1:0]    nsteps_l, nsteps_l_nxt;
    logic                tick_clr, tick_en, tick;
    logic [NLAMP-1:0]    adv_lamp;
    logic                adv_dir_up;

    // Prescaler only runs while stepping is live; HOLD with pause released counts as live.
    assign tick_en  = ((state == RUN) || (state == HOLD)) && !pause && !stop;
    assign step_inc = step + CNT_W'(1);

    lamp_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk  (clk),
        .rset (rset),
        .clr  (tick_clr),
        .en   (tick_en),
        .div  (div_l),
        .tick (tick)
    );

    // Next pattern for one advance in the latched mode.
    always_comb begin
        adv_lamp   = lamp;
        adv_dir_up = dir_up;
        case (mode_l)
            MODE_FWD: adv_lamp = (lamp << 1) | (lamp >> (NLAMP - 1));
            MODE_REV: adv_lamp = (lamp >> 1) | (lamp << (NLAMP - 1));
            MODE_PP: begin
                if (NLAMP == 1) begin
                    adv_lamp = lamp;
                end else if (dir_up) begin
                    if (lamp[NLAMP-1]) begin
                        adv_lamp   = lamp >> 1;
                        adv_dir_up = 1'b0;
                    end else begin
                        adv_lamp = lamp << 1;
                    end
                end else begin
                    if (lamp[0]) begin
                        adv_lamp   = lamp << 1;
                        adv_dir_up = 1'b1;
                    end else begin
                        adv_lamp = lamp >> 1;
                    end
                end
            end
            default: adv_lamp = ~lamp;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        lamp_nxt     = lamp;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        dir_up_nxt   = dir_up;
        step_nxt     = step;
        mode_l_nxt   = mode_l;
        div_l_nxt    = div_l;
        nsteps_l_nxt = nsteps_l;
        tick_clr     = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    mode_l_nxt   = mode;
                    div_l_nxt    = div;
                    nsteps_l_nxt = nsteps;
                    tick_clr     = 1'b1;
                    step_nxt     = '0;
                    dir_up_nxt   = 1'b1;
                    busy_nxt     = 1'b1;
                    state_nxt    = RUN;
                    case (mode)
                        MODE_FWD: lamp_nxt = LAMP_LSB;
                        MODE_REV: lamp_nxt = LAMP_MSB;
                        MODE_PP:  lamp_nxt = LAMP_LSB;
                        default:  lamp_nxt = LAMP_ALL;
                    endcase
                end
            end
            RUN, HOLD: begin
                if (stop) begin
                    state_nxt = IDLE;
                    lamp_nxt  = '0;
                    busy_nxt  = 1'b0;
                end else if (pause) begin
                    state_nxt = HOLD;
                end else begin
                    state_nxt = RUN;
                    if (tick) begin
                        step_nxt = step_inc;
                        // The final advance is never displayed.
                        if ((nsteps_l != '0) && (step_inc == nsteps_l)) begin
                            state_nxt = DONE;
                            lamp_nxt  = '0;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end else begin
                            lamp_nxt   = adv_lamp;
                            dir_up_nxt = adv_dir_up;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                lamp_nxt  = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            state    <= IDLE;
            lamp     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dir_up   <= 1'b0;
            step     <= '0;
            mode_l   <= '0;
            div_l    <= '0;
            nsteps_l <= '0;
        end else begin
            state    <= state_nxt;
            lamp     <= lamp_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            dir_up   <= dir_up_nxt;
            step     <= step_nxt;
            mode_l   <= mode_l_nxt;
            div_l    <= div_l_nxt;
            nsteps_l <= nsteps_l_nxt;
        end
    end

endmodule

// File: tb/tb_lamp_chase_ctrl.sv
// Scoreboard bench for lamp_chase_ctrl: per-cycle expected {lamp,busy,done} is queued
// as stimulus is applied and compared one clock later.
module tb_lamp_chase_ctrl;

    logic        clk;
    logic        rset;
    logic        start;
    logic        stop;
    logic        pause;
    logic [1:0]  mode;
    logic [15:0] div;
    logic [7:0]  nsteps;
    logic [3:0]  lamp;
    logic        busy;
    logic        done;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [5:0] exp_q[$];
    string      tag_q[$];

    lamp_chase_ctrl #(.NLAMP(4), .DIV_W(16), .CNT_W(8)) dut (
        .clk    (clk),
        .rset   (rset),
        .start  (start),
        .stop   (stop),
        .pause  (pause),
        .mode   (mode),
        .div    (div),
        .nsteps (nsteps),
        .lamp   (lamp),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s lamp/busy/done got=%b_%b_%b exp=%b_%b_%b",
                     tag, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of control inputs, queue the expected result, then sample after the edge.
    task automatic cyc(input logic st, input logic sp, input logic pa,
                       input logic [3:0] el, input logic eb, input logic ed, input string tag);
        logic [5:0] e;
        string      t;
        start = st;
        stop  = sp;
        pause = pa;
        exp_q.push_back({el, eb, ed});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, {lamp, busy, done}, e);
    endtask

    task automatic cfg(input logic [1:0] m, input logic [15:0] d, input logic [7:0] n);
        mode   = m;
        div    = d;
        nsteps = n;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rset  = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        cfg(2'b00, 16'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset", {lamp, busy, done}, 6'b0000_0_0);
        rset = 1'b0;
        cyc(0, 0, 0, 4'b0000, 0, 0, "idle_after_reset");

        // Forward, tick every second clock, three advances to completion.
        cfg(2'b00, 16'd1, 8'd3);
        cyc(1, 0, 0, 4'b0001, 1, 0, "fwd_e0");
        cyc(0, 0, 0, 4'b0001, 1, 0, "fwd_e1");
        cyc(0, 0, 0, 4'b0010, 1, 0, "fwd_e2");
        cyc(0, 0, 0, 4'b0010, 1, 0, "fwd_e3");
        cyc(0, 0, 0, 4'b0100, 1, 0, "fwd_e4");
        cyc(0, 0, 0, 4'b0100, 1, 0, "fwd_e5");
        cyc(0, 0, 0, 4'b0000, 0, 1, "fwd_done");
        cyc(0, 0, 0, 4'b0000, 0, 0, "fwd_idle");

        // Ping-pong free run at full rate.
        cfg(2'b10, 16'd0, 8'd0);
        cyc(1, 0, 0, 4'b0001, 1, 0, "pp_0");
        cyc(0, 0, 0, 4'b0010, 1, 0, "pp_1");
        cyc(0, 0, 0, 4'b0100, 1, 0, "pp_2");
        cyc(0, 0, 0, 4'b1000, 1, 0, "pp_3");
        cyc(0, 0, 0, 4'b0100, 1, 0, "pp_4");
        cyc(0, 0, 0, 4'b0010, 1, 0, "pp_5");
        cyc(0, 0, 0, 4'b0001, 1, 0, "pp_6");
        cyc(0, 0, 0, 4'b0010, 1, 0, "pp_7");
        cyc(0, 1, 0, 4'b0000, 0, 0, "pp_stop");

        // Pause for ten clocks shifts the next tick by exactly ten clocks.
        cfg(2'b00, 16'd3, 8'd0);
        cyc(1, 0, 0, 4'b0001, 1, 0, "pz_start");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4'b0001, 1, 0, "pz_pre");
        cyc(0, 0, 0, 4'b0010, 1, 0, "pz_tick1");
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 4'b0010, 1, 0, "pz_hold");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4'b0010, 1, 0, "pz_resume");
        cyc(0, 0, 0, 4'b0100, 1, 0, "pz_tick2");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4'b0100, 1, 0, "pz_gap");
        cyc(0, 0, 0, 4'b1000, 1, 0, "pz_tick3");

        // Stop in HOLD with start held: stop wins, restart on the following clock.
        cyc(0, 0, 1, 4'b1000, 1, 0, "hold_enter");
        cyc(1, 0, 1, 4'b1000, 1, 0, "hold_start_ignored");
        cyc(1, 1, 1, 4'b0000, 0, 0, "hold_stop");
        cyc(1, 0, 0, 4'b0001, 1, 0, "restart");
        cyc(0, 1, 0, 4'b0000, 0, 0, "restart_stop");

        // Reverse, two advances.
        cfg(2'b01, 16'd0, 8'd2);
        cyc(1, 0, 0, 4'b1000, 1, 0, "rev_0");
        cyc(0, 0, 0, 4'b0100, 1, 0, "rev_1");
        cyc(0, 0, 0, 4'b0000, 0, 1, "rev_done");
        cyc(0, 0, 0, 4'b0000, 0, 0, "rev_idle");

        // Blink with a mid-run start carrying a different config.
        cfg(2'b11, 16'd0, 8'd2);
        cyc(1, 0, 0, 4'b1111, 1, 0, "blink_0");
        cfg(2'b00, 16'd5, 8'd5);
        cyc(1, 0, 0, 4'b0000, 1, 0, "blink_1");
        cyc(0, 0, 0, 4'b0000, 0, 1, "blink_done");
        cyc(0, 0, 0, 4'b0000, 0, 0, "blink_idle");

        // Start held high through DONE restarts only from IDLE.
        cfg(2'b01, 16'd0, 8'd2);
        cyc(1, 0, 0, 4'b1000, 1, 0, "hold_st_0");
        cyc(1, 0, 0, 4'b0100, 1, 0, "hold_st_1");
        cyc(1, 0, 0, 4'b0000, 0, 1, "hold_st_done");
        cyc(1, 0, 0, 4'b0000, 0, 0, "hold_st_idle");
        cyc(1, 0, 0, 4'b1000, 1, 0, "hold_st_rerun");
        cyc(0, 1, 0, 4'b0000, 0, 0, "hold_st_stop");

        // Asynchronous reset mid-run.
        cfg(2'b00, 16'd0, 8'd0);
        cyc(1, 0, 0, 4'b0001, 1, 0, "rst_run_0");
        cyc(0, 0, 0, 4'b0010, 1, 0, "rst_run_1");
        #2;
        rset = 1'b1;
        #1;
        check_eq("rst_async", {lamp, busy, done}, 6'b0000_0_0);
        @(posedge clk);
        #1;
        rset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4'b0000, 0, 0, "post_rst_idle");
        cyc(1, 0, 0, 4'b0001, 1, 0, "post_rst_start");
        cyc(0, 0, 0, 4'b0010, 1, 0, "post_rst_step");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lamp_chase_ctrl.md
Name: lamp_chase_ctrl

Overview:
Sequencer and configurator for the one-hot lamp chaser datapath. It accepts a start command with mode, speed and run length, then drives the lamp bank one step per prescaled tick. It supports pause and stop, and reports busy and done. It sits between the board-level control (switches or CPU register) and the lamp outputs, and replaces free-running chasers with a commanded one.

Parameters:
NLAMP, 4, number of lamps driven; must be at least 1.
DIV_W, 16, width of the prescaler divide value.
CNT_W, 8, width of the step-count limit.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rset  in  1  asynchronous, active-high reset.
start  in  1  level-sampled start command; acted on only in IDLE.
stop  in  1  abort command; acted on in any state.
pause  in  1  level; while high, RUN freezes in HOLD.
mode  in  2  pattern select: 00 forward, 01 reverse, 10 ping-pong, 11 blink-all.
div  in  DIV_W  tick period minus 1, in clocks.
nsteps  in  CNT_W  number of advances before completion; 0 means free-run.
lamp  out  NLAMP  lamp drive, registered.
busy  out  1  high in RUN and HOLD.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rset=1): state=IDLE, lamp=0, busy=0, done=0, prescaler=0, step counter=0, latched config=0.
- States: IDLE, RUN, HOLD, DONE.
- IDLE:
  - On start=1 and stop=0: latch mode, div and nsteps; clear prescaler and step counter.
  - Load the initial pattern at that same edge: fwd=bit0, rev=bit NLAMP-1, ping-pong=bit0 with direction up, blink=all ones.
  - Set busy=1 and go to RUN. The lamp changes on the edge that samples start (latency 1).
- Prescaler: counts 0..div_latched. A tick occurs on the clock where the count equals div_latched; the count then wraps to 0. div=0 gives a tick every clock.
- RUN, on each tick:
  - Advance the pattern and increment the step counter.
  - fwd: rotate left, bit NLAMP-1 wraps to bit0.
  - rev: rotate right, bit0 wraps to bit NLAMP-1.
  - ping-pong: move toward the current end and reverse at bit0 and bit NLAMP-1 without repeating the endpoint (0,1,2,3,2,1,0,1...). With NLAMP=1 it stays on bit0.
  - blink: toggle between all ones and all zeros.
- Completion: if nsteps!=0 and the incremented step count equals nsteps, the advance is not shown. At that edge go to DONE with lamp=0, busy=0, done=1. The next edge goes to IDLE with done=0.
- Free-run (nsteps=0): the step counter wraps at 2^CNT_W and never completes.
- HOLD: entered from RUN when pause=1; the prescaler and lamp are frozen. Return to RUN when pause=0 and resume the prescaler count from where it stopped. A tick coincident with pause=1 is discarded, because pause has priority.
- stop=1 in RUN, HOLD or DONE: next edge state=IDLE, lamp=0, busy=0, done=0, with no done pulse. stop has priority over start, pause and a completing tick.
- start while busy is ignored, and config inputs are not re-sampled mid-run.
- start held high through DONE: a new run begins from the IDLE cycle that follows, never directly from DONE.
- Reset mid-run: immediate return to reset values; no done pulse.

Decomposition:
- Shared package lamp_pkg: state enum (IDLE, RUN, HOLD, DONE) and mode encodings MODE_FWD=2'b00, MODE_REV=2'b01, MODE_PP=2'b10, MODE_BLINK=2'b11.
- Sub-module lamp_tick_gen: prescaler with inputs clk, rset, clr, en, div, and output tick.
- lamp_chase_ctrl holds the FSM, pattern register, direction flag and step counter.

Test Plan:
- Reset with rset=1 mid-run -> lamp=0000, busy=0, done=0 immediately; no activity after release until start.
- Forward run (NLAMP=4, div=1, nsteps=3), start at edge 0 -> lamp 0001@e0, 0010@e2, 0100@e4; lamp=0000, done=1, busy=0 @e6; done=0 @e7.
- Ping-pong (div=0, nsteps=0), 8 clocks -> 0001,0010,0100,1000,0100,0010,0001,0010; busy stays 1, done never asserts.
- Pause (fwd, div=3): raise pause for 10 clocks after the lamp shows 0010 -> lamp holds 0010 and the tick spacing resumes with its remaining count; total step timing is shifted by exactly 10 clocks.
- Stop while start=1, during HOLD -> next edge lamp=0000, busy=0, done=0; the restart happens on the following clock because start is still high in IDLE.
- Reverse and blink (nsteps=2, div=0) -> rev: 1000, 0100, then done. blink: 1111, 0000, then done. A start pulse issued mid-run is ignored with no config change.
